// File: rtl/nbitmux_arb_if.sv
// Handshake bundle between four source channels, the merge stage and its single output stream.
// Signals: el (active-low enable), i1..i4/v1..v4/r1..r4 (source data/valid/grant),
//          y/sel/y_valid/y_ready (merged output word, its source tag and handshake).
interface nbitmux_arb_if #(
    parameter int WIDTH = 16
);
    logic             el;
    logic [WIDTH-1:0] i1, i2, i3, i4;
    logic             v1, v2, v3, v4;
    logic             r1, r2, r3, r4;
    logic [WIDTH-1:0] y;
    logic [1:0]       sel;
    logic             y_valid;
    logic             y_ready;

    // Merge stage side.
    modport slave (
        input  el, i1, i2, i3, i4, v1, v2, v3, v4, y_ready,
        output r1, r2, r3, r4, y, sel, y_valid
    );

    // Environment side: drives the sources and consumes the output.
    modport master (
        output el, i1, i2, i3, i4, v1, v2, v3, v4, y_ready,
        input  r1, r2, r3, r4, y, sel, y_valid
    );
endinterface

// File: rtl/nbitmux_arb.sv
// Purpose: round-robin merge of four valid/ready channels into one registered, tagged output word.
// Latency: one cycle from grant to y/y_valid; one word per cycle sustained (drain and load may overlap).
// Backpressure: while y_valid=1 and y_ready=0 no grants are issued and y/sel stay stable.
// Ports: clk, rst (async active-high), bus (nbitmux_arb_if.slave: el, i1..i4, v1..v4, r1..r4,
//        y, sel, y_valid, y_ready).
module nbitmux_arb #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    nbitmux_arb_if.slave bus
);

    logic [WIDTH-1:0] r_y;
    logic [1:0]       r_sel;
    logic             r_y_valid;
    logic [1:0]       r_ptr;

    logic [3:0]       w_vld;
    logic             w_any;
    logic             w_load;
    logic [1:0]       w_c1, w_c2, w_c3;
    logic [1:0]       w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_dat;
    logic [3:0]       w_gnt;

    assign w_vld = {bus.v4, bus.v3, bus.v2, bus.v1};
    assign w_any = |w_vld;

    // The output slot is free when empty or being drained this cycle; rst suppresses grants.
    assign w_load = !rst && !bus.el && (!r_y_valid || bus.y_ready) && w_any;

    // Search order ptr, ptr+1, ptr+2, ptr+3 (2-bit wraparound gives the mod 4).
    assign w_c1 = r_ptr + 2'd1;
    assign w_c2 = r_ptr + 2'd2;
    assign w_c3 = r_ptr + 2'd3;

    always_comb begin
        if (w_vld[r_ptr])     w_gnt_idx = r_ptr;
        else if (w_vld[w_c1]) w_gnt_idx = w_c1;
        else if (w_vld[w_c2]) w_gnt_idx = w_c2;
        else                  w_gnt_idx = w_c3;
    end

    always_comb begin
        case (w_gnt_idx)
            2'd0:    w_gnt_dat = bus.i1;
            2'd1:    w_gnt_dat = bus.i2;
            2'd2:    w_gnt_dat = bus.i3;
            default: w_gnt_dat = bus.i4;
        endcase
    end

    assign w_gnt  = w_load ? (4'b0001 << w_gnt_idx) : 4'b0000;
    assign bus.r1 = w_gnt[0];
    assign bus.r2 = w_gnt[1];
    assign bus.r3 = w_gnt[2];
    assign bus.r4 = w_gnt[3];

    // Channel index 0..3 maps to tag 01,10,11,00, i.e. index+1 mod 4; the next pointer
    // is the same value, so one adder serves both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y       <= '0;
            r_sel     <= 2'b00;
            r_y_valid <= 1'b0;
            r_ptr     <= 2'd0;
        end else if (w_load) begin
            r_y       <= w_gnt_dat;
            r_sel     <= w_gnt_idx + 2'd1;
            r_y_valid <= 1'b1;
            r_ptr     <= w_gnt_idx + 2'd1;
        end else if (r_y_valid && bus.y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign bus.y       = r_y;
    assign bus.sel     = r_sel;
    assign bus.y_valid = r_y_valid;

endmodule
